// File: rtl/sgd_pkg.sv
// rtl/sgd_pkg.sv - shared widths, header placement and defaults for the SGD result sender
package sgd_pkg;

    localparam int WORD_W              = 512;
    localparam int KEEP_W              = WORD_W / 8;
    localparam int HDR_LSB             = 480;
    localparam int DEF_ENGINE_NUM      = 8;
    localparam int DEF_NUM_OF_BANKS    = 8;
    localparam int DEF_FIFO_DEPTH_BITS = 6;
    localparam int DEF_SEQ_WRAP        = 128;

    // Byte 0 of the result becomes byte KEEP_W-1 of the wire word (network order).
    function automatic logic [WORD_W-1:0] byte_reverse(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
        r = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            r[8*i +: 8] = w[WORD_W-8-8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sgd_result_sender_if.sv
// rtl/sgd_result_sender_if.sv - 512-bit single-beat stream interface used for the result packets
interface axi_stream;
    import sgd_pkg::*;

    logic [WORD_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);

endinterface

// File: rtl/distram_fifo.sv
// rtl/distram_fifo.sv - first-word-fall-through FIFO of arbitrary depth; writes when full are ignored
module distram_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr, do_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_wr   = wr_en && (count_q != CNT_W'(DEPTH));
    assign do_rd   = rd_en && (count_q != '0);
    assign count_d = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/sgd_sat_adder_tree.sv
// rtl/sgd_sat_adder_tree.sv - pipelined N-input signed adder tree, saturated to 32 bits; latency log2(N)+2
module sgd_sat_adder_tree
    import sgd_pkg::*;
#(
    parameter int N = DEF_ENGINE_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [N-1:0][31:0] in_data,
    output logic              out_valid,
    output logic [31:0]       out_data
);
    localparam int L = $clog2(N);
    localparam int W = 32 + L;

    // Heap layout: leaves at N..2N-1, node k sums children 2k and 2k+1, root at 1.
    logic signed [W-1:0] node_q [2*N];
    logic signed [W-1:0] root;
    logic        [31:0]  sat_d, out_q;
    logic        [L+1:0] vld_q;

    always_ff @(posedge clk) begin
        node_q[0] <= '0;
        for (int k = 1; k < N; k++) begin
            node_q[k] <= node_q[2*k] + node_q[2*k+1];
        end
        for (int k = 0; k < N; k++) begin
            node_q[N+k] <= {{L{in_data[k][31]}}, in_data[k]};
        end
        out_q <= sat_d;
    end

    always_comb begin
        root = node_q[1];
        if (root[W-1:31] == {(W-31){root[W-1]}}) sat_d = root[31:0];
        else                                     sat_d = root[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end

    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= {vld_q[L:0], in_valid};
    end

    assign out_valid = vld_q[L+1];
    assign out_data  = out_q;

endmodule

// File: rtl/sgd_result_sender.sv
// rtl/sgd_result_sender.sv - gathers per-engine dot products, sums them per bank and streams sequenced packets
module sgd_result_sender
    import sgd_pkg::*;
#(
    parameter int ENGINE_NUM      = DEF_ENGINE_NUM,
    parameter int NUM_OF_BANKS    = DEF_NUM_OF_BANKS,
    parameter int FIFO_DEPTH_BITS = DEF_FIFO_DEPTH_BITS,
    parameter int SEQ_WRAP        = DEF_SEQ_WRAP
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [ENGINE_NUM-1:0][NUM_OF_BANKS-1:0][31:0] dot_product_signed,
    input  logic [ENGINE_NUM-1:0]                       dot_product_signed_valid,
    output logic [ENGINE_NUM-1:0]                       in_afull,
    input  logic                                        cfg_byte_swap,
    output logic [31:0]                                 drop_cnt,
    axi_stream.master                                   m_axis_tx_data
);
    localparam int LOG_E     = $clog2(ENGINE_NUM);
    localparam int IN_DEPTH  = 2 ** FIFO_DEPTH_BITS;
    localparam int IN_CNT_W  = $clog2(IN_DEPTH + 1);
    localparam int OUT_DEPTH = 4 + LOG_E + 2;
    localparam int OUT_CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int CRED_W    = $clog2(OUT_DEPTH + 1);
    localparam int BANK_W    = NUM_OF_BANKS * 32;

    logic [NUM_OF_BANKS-1:0][31:0] in_rd [ENGINE_NUM];
    logic [IN_CNT_W-1:0]           in_cnt [ENGINE_NUM];
    logic [ENGINE_NUM-1:0]         in_full, in_empty;
    logic                          pop;

    logic [ENGINE_NUM-1:0][31:0]   tree_in [NUM_OF_BANKS];
    logic [NUM_OF_BANKS-1:0][31:0] tree_sum;
    logic [NUM_OF_BANKS-1:0]       tree_vld;

    logic [NUM_OF_BANKS-1:0][31:0] out_head;
    logic [OUT_CNT_W-1:0]          out_cnt;
    logic                          load, hs;

    logic [CRED_W-1:0]             credit_q, credit_d;
    logic [31:0]                   seq_q, seq_next;
    logic [31:0]                   drop_cnt_q, drop_cnt_d;
    logic [4:0]                    drop_k;
    logic [32:0]                   drop_sum;
    logic                          tvalid_q;
    logic [WORD_W-1:0]             tdata_q, raw_word, tdata_d;

    for (genvar e = 0; e < ENGINE_NUM; e++) begin : g_in
        distram_fifo #(.WIDTH(BANK_W), .DEPTH(IN_DEPTH)) u_in_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (dot_product_signed_valid[e]),
            .wr_data (dot_product_signed[e]),
            .rd_en   (pop),
            .rd_data (in_rd[e]),
            .count   (in_cnt[e])
        );
        assign in_full[e]  = (in_cnt[e] == IN_CNT_W'(IN_DEPTH));
        assign in_empty[e] = (in_cnt[e] == '0);
        assign in_afull[e] = (in_cnt[e] >= IN_CNT_W'(IN_DEPTH - 4));
    end

    // A pop is only allowed when the output side is guaranteed room for the result.
    assign pop = (in_empty == '0) && (credit_q != '0);

    always_comb begin
        for (int b = 0; b < NUM_OF_BANKS; b++) begin
            for (int e = 0; e < ENGINE_NUM; e++) begin
                tree_in[b][e] = in_rd[e][b];
            end
        end
    end

    for (genvar b = 0; b < NUM_OF_BANKS; b++) begin : g_bank
        sgd_sat_adder_tree #(.N(ENGINE_NUM)) u_tree (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (pop),
            .in_data   (tree_in[b]),
            .out_valid (tree_vld[b]),
            .out_data  (tree_sum[b])
        );
    end

    distram_fifo #(.WIDTH(BANK_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (&tree_vld),
        .wr_data (tree_sum),
        .rd_en   (load),
        .rd_data (out_head),
        .count   (out_cnt)
    );

    assign hs       = tvalid_q && m_axis_tx_data.tready;
    assign load     = (out_cnt != '0) && (!tvalid_q || m_axis_tx_data.tready);
    assign seq_next = (seq_q == 32'(SEQ_WRAP - 1)) ? '0 : seq_q + 32'd1;
    assign credit_d = credit_q - CRED_W'(pop) + CRED_W'(hs);

    // A word loaded in the same cycle as a handshake carries the following sequence number.
    always_comb begin
        raw_word                 = '0;
        raw_word[HDR_LSB +: 32]  = hs ? seq_next : seq_q;
        raw_word[BANK_W-1:0]     = out_head;
        tdata_d                  = cfg_byte_swap ? byte_reverse(raw_word) : raw_word;
    end

    always_comb begin
        drop_k = '0;
        for (int e = 0; e < ENGINE_NUM; e++) begin
            drop_k = drop_k + {4'd0, (dot_product_signed_valid[e] && in_full[e])};
        end
        drop_sum   = {1'b0, drop_cnt_q} + 33'(drop_k);
        drop_cnt_d = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q   <= CRED_W'(OUT_DEPTH);
            seq_q      <= '0;
            drop_cnt_q <= '0;
            tvalid_q   <= 1'b0;
        end else begin
            credit_q   <= credit_d;
            drop_cnt_q <= drop_cnt_d;
            if (hs)        seq_q    <= seq_next;
            if (load)      tvalid_q <= 1'b1;
            else if (hs)   tvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) tdata_q <= tdata_d;
    end

    assign drop_cnt              = drop_cnt_q;
    assign m_axis_tx_data.tvalid = tvalid_q;
    assign m_axis_tx_data.tdata  = tdata_q;
    assign m_axis_tx_data.tkeep  = '1;
    assign m_axis_tx_data.tlast  = 1'b1;

endmodule

// File: doc/sgd_result_sender.md
SGD_RESULT_SENDER -- requirements
Module: sgd_result_sender

Interface
REQ-001 SHALL have parameter ENGINE_NUM, default 8, number of contributing engines (power of two, 2..16).
REQ-002 SHALL have parameter NUM_OF_BANKS, default 8, 32-bit dot products per engine (1..15).
REQ-003 SHALL have parameter FIFO_DEPTH_BITS, default 6, log2 depth of each per-engine input FIFO.
REQ-004 SHALL have parameter SEQ_WRAP, default 128, packet sequence number modulus.
REQ-005 SHALL have port clk  in  1  sole clock.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port dot_product_signed  in  ENGINE_NUM x NUM_OF_BANKS x 32  signed per-bank dot products.
REQ-008 SHALL have port dot_product_signed_valid  in  ENGINE_NUM  one bit per engine, qualifies that engine's full bank vector.
REQ-009 SHALL have port in_afull  out  ENGINE_NUM  per-engine almost-full.
REQ-010 SHALL have port cfg_byte_swap  in  1  1 = byte-reverse 512-bit word (network order), 0 = native.
REQ-011 SHALL have port drop_cnt  out  32  saturating count of dropped input vectors.
REQ-012 SHALL have port m_axis_tx_data  axi_stream.master  512-bit data, 64-bit keep, valid, ready, last.

Function
REQ-013 SHALL buffer each engine in its own FIFO, 2**FIFO_DEPTH_BITS entries of NUM_OF_BANKS*32 bits.
REQ-014 SHALL assert in_afull[e] while FIFO e holds >= depth-4 entries.
REQ-015 SHALL discard a write to a full FIFO, leave FIFO contents unchanged, and increment drop_cnt (holds at 0xFFFFFFFF); simultaneous drops on k engines add k.
REQ-016 SHALL pop all engine FIFOs in the same cycle only when every FIFO is non-empty and the output credit counter is non-zero; no partial pops.
REQ-017 SHALL sum, per bank, the ENGINE_NUM popped values in a pipelined tree at 32+log2(ENGINE_NUM) bits, saturating the result to signed 32-bit range (0x7FFFFFFF / 0x80000000).
REQ-018 SHALL have fixed latency pop -> output-FIFO write of log2(ENGINE_NUM)+2 cycles.
REQ-019 SHALL place results in an output FIFO of depth 4+log2(ENGINE_NUM)+2; credit counter initialised to that depth, decremented on pop, incremented on output handshake, both in one cycle leave it unchanged.
REQ-020 SHALL form the output word as seq[31:0] in bits 511:480, zeros below, bank b at bits 32b+31:32b; byte-reversed when cfg_byte_swap=1 (sampled at output-FIFO read).
REQ-021 SHALL drive keep all ones and last=1 on every beat (single-beat packets).
REQ-022 SHALL hold valid and data stable until ready; valid never deasserts without handshake.
REQ-023 SHALL increment seq only on valid&ready, wrapping SEQ_WRAP-1 -> 0.
REQ-024 SHALL never lose or reorder a popped vector regardless of ready pattern.

Reset
REQ-025 SHALL on rst: empty all FIFOs, clear tree pipeline valids, seq=0, drop_cnt=0, credits=full, m_axis valid=0, in_afull=0.
REQ-026 SHALL discard in-flight tree results when rst asserts mid-operation; first packet after reset carries seq 0.

Structure
REQ-027 SHALL take word width 512, header position and default parameter values from shared package sgd_pkg.
REQ-028 SHALL implement the saturating tree as sub-module sgd_sat_adder_tree, instantiated once per bank.
REQ-029 SHALL reuse distram_fifo for input and output FIFOs.

Verification
REQ-030 ENGINE_NUM=8, all engines valid, bank b = b+1 per engine, ready=1 -> one beat, bank b = 8(b+1), seq=0, latency 5 cycles after pop.
REQ-031 Engines 0..6 valid, engine 7 delayed 20 cycles -> no output until engine 7 writes; then one correct sum.
REQ-032 All engines 0x7FFFFFFF bank 0, 0x80000000 bank 1 -> bank 0 = 0x7FFFFFFF, bank 1 = 0x80000000.
REQ-033 200 vectors, ready toggling random 30% -> 200 beats, seq 0..127,0..71, data stable while stalled, no loss.
REQ-034 ready=0, 80 writes engine 0 -> in_afull[0] at 60 entries, drop_cnt=16.
REQ-035 cfg_byte_swap=1, seq=5 -> data byte 3 = 0x05, bytes 0..2 = 0x00.
